uart_frame_sched: RTL and testbench

Parametrised frame scheduler sitting between game logic and the UART transmitter. Snapshots a multi-byte data word, optionally prefixes a sync byte, and feeds the bytes one at a time to the UART with a single-cycle `tx_start` per byte. Advances on the transmitter's `tx_done`, or on a per-byte timeout if `tx_done` never arrives. Frames are sent either back-to-back with a programmable hold-off, or only when the data word changes.

---
 rtl/uart_frame_sched.sv | 139 +++++++++++++
 tb/tb_uart_frame_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// uart_frame_sched
//   Frame scheduler between game logic and a byte-wide UART transmitter.
//   Snapshots a BYTES-wide payload word, optionally prefixes SYNC_BYTE, and
//   hands the bytes to the UART one at a time with a one-cycle tx_start.
//   A byte is retired on tx_done, or forced out after BYTE_TIMEOUT cycles.
//   Frames repeat (with HOLDOFF idle cycles between them) or, in on-change
//   mode, are sent only when the payload differs from the last sent word.
//
// Ports
//   pclk        system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          permits a new frame (sampled in IDLE only)
//   on_change   1 = send only when data_in differs from last sent word
//   data_in     payload word, most significant byte transmitted first
//   tx_done     byte-finished pulse from the UART
//   tx_start    start strobe to the UART (one cycle per byte)
//   data_out    byte to the UART, held until the next tx_start
//   busy        high whenever a frame or hold-off is in progress
//   frame_done  pulse after the last byte of a frame
//   tx_timeout  pulse when a byte was retired by timeout
module uart_frame_sched #(
  parameter int         BYTES        = 2,
  parameter int         SYNC_EN      = 1,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 28700,
  parameter int         HOLDOFF      = 0,
  parameter int         CNT_W        = 15
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               on_change,
  input  logic [8*BYTES-1:0] data_in,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         data_out,
  output logic               busy,
  output logic               frame_done,
  output logic               tx_timeout
);

  localparam int N     = BYTES + SYNC_EN;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(BYTE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [8*BYTES-1:0] snap;
  logic [8*BYTES-1:0] last_word;
  logic               last_valid;

  // Byte i of a frame: sync header first (if enabled), then payload MSB first.
  function automatic logic [7:0] byte_at(input logic [8*BYTES-1:0] w,
                                         input logic [IDX_W-1:0]   i);
    int p;
    if (SYNC_EN != 0 && i == '0) return SYNC_BYTE;
    p = int'(i) - SYNC_EN;
    return w[8*(BYTES-1-p) +: 8];
  endfunction

  // Outputs are registered, so tx_start/data_out are loaded on the edge that
  // enters START; they are therefore high/valid for exactly the START cycle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap       <= '0;
      last_word  <= '0;
      last_valid <= 1'b0;
      tx_start   <= 1'b0;
      data_out   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (!on_change || !last_valid || data_in != last_word)) begin
            snap     <= data_in;
            idx      <= '0;
            cnt      <= '0;
            state    <= START;
            busy     <= 1'b1;
            tx_start <= 1'b1;
            // data_in is the value being snapshotted on this very edge.
            data_out <= byte_at(data_in, '0);
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done || cnt == TO_LAST) begin
            tx_timeout <= !tx_done;
            cnt        <= '0;
            if (idx != IDX_LAST) begin
              idx      <= idx + 1'b1;
              state    <= START;
              tx_start <= 1'b1;
              data_out <= byte_at(snap, idx + 1'b1);
            end else begin
              last_word  <= snap;
              last_valid <= 1'b1;
              frame_done <= 1'b1;
              if (HOLDOFF > 0) begin
                state <= HOLD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Testbench for uart_frame_sched: randomized frames, tx_done delays and
// timeouts, on-change gating and a mid-frame asynchronous reset. A timeline
// model predicts, per cycle, every strobe, busy and the byte on data_out.
module tb_uart_frame_sched;

  localparam int         BYTES = 2;
  localparam int         SYNC  = 1;
  localparam logic [7:0] SB    = 8'hA5;
  localparam int         T     = 20;
  localparam int         H     = 3;
  localparam int         CW    = 5;
  localparam int         N     = BYTES + SYNC;
  localparam int         MAXC  = 16384;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        on_change = 1'b0;
  logic [15:0] data_in = '0;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  data_out;
  logic        busy;
  logic        frame_done;
  logic        tx_timeout;

  uart_frame_sched #(
    .BYTES(BYTES), .SYNC_EN(SYNC), .SYNC_BYTE(SB),
    .BYTE_TIMEOUT(T), .HOLDOFF(H), .CNT_W(CW)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .on_change(on_change),
    .data_in(data_in), .tx_done(tx_done), .tx_start(tx_start),
    .data_out(data_out), .busy(busy), .frame_done(frame_done),
    .tx_timeout(tx_timeout)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Expected timeline, indexed by cycle number.
  bit         exp_ts[MAXC];
  bit         exp_fd[MAXC];
  bit         exp_to[MAXC];
  bit         exp_bz[MAXC];
  bit         drv_done[MAXC];
  logic [7:0] exp_by[MAXC];

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  mdout = '0;
  logic [15:0] last_word = '0;
  bit          last_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Advance to the middle of the next cycle, compare, then drive tx_done.
  task automatic step();
    @(negedge pclk);
    if (exp_ts[cyc]) mdout = exp_by[cyc];
    check_eq("tx_start",   32'(tx_start),   32'(exp_ts[cyc]));
    check_eq("frame_done", 32'(frame_done), 32'(exp_fd[cyc]));
    check_eq("tx_timeout", 32'(tx_timeout), 32'(exp_to[cyc]));
    check_eq("busy",       32'(busy),       32'(exp_bz[cyc]));
    check_eq("data_out",   32'(data_out),   32'(mdout));
    tx_done = drv_done[cyc];
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_start"},   32'(tx_start),   0);
    check_eq({tag, "_data_out"},   32'(data_out),   0);
    check_eq({tag, "_busy"},       32'(busy),       0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 0);
    check_eq({tag, "_tx_timeout"}, 32'(tx_timeout), 0);
  endtask

  // Frame accepted in IDLE cycle i: first byte starts at i+1. A byte started
  // at s and answered d cycles later (d <= T) restarts at s+d+1; unanswered
  // bytes restart at s+T+1 with a timeout pulse. Returns next IDLE cycle.
  task automatic plan_frame(input int i, input logic [15:0] w, input bit force_long,
                            output int nxt);
    logic [7:0] by[N];
    int s, n, d, r;
    bit to;
    by  = '{SB, w[15:8], w[7:0]};
    s   = i + 1;
    nxt = s;
    for (int j = 0; j < N; j++) begin
      exp_ts[s] = 1'b1;
      exp_by[s] = by[j];
      if ($urandom_range(0, 3) == 0) drv_done[s] = 1'b1;  // ignored in START
      r = int'($urandom_range(0, 9));
      if (force_long && j == 0) d = T + 1;
      else if (r < 2)           d = T + 1;
      else if (r == 2)          d = T;
      else if (r == 3)          d = 1;
      else                      d = int'($urandom_range(1, T));
      to = (d > T);
      if (!to) drv_done[s + d] = 1'b1;
      n = s + (to ? T : d) + 1;
      for (int c = s; c < n; c++) exp_bz[c] = 1'b1;
      exp_to[n] = to;
      if (j < N - 1) begin
        s = n;
      end else begin
        exp_fd[n] = 1'b1;
        for (int c = n; c < n + H; c++) begin
          exp_bz[c] = 1'b1;
          if ($urandom_range(0, 2) == 0) drv_done[c] = 1'b1;  // ignored in HOLD
        end
        nxt = n + H;
      end
    end
  endtask

  initial begin
    int  i, nxt;
    bit  send, post_rst;
    post_rst = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    rst_n = 1'b1;
    i = cyc;

    for (int k = 0; k < 480; k++) begin
      if (i > MAXC - 200) break;
      if (post_rst) begin
        en = 1'b1; on_change = 1'b1; data_in = last_word; post_rst = 1'b0;
      end else if (k < 150) begin
        en        = ($urandom_range(0, 9) < 7);
        on_change = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0, 1:    data_in = 16'h1234;
          2:       data_in = 16'h1235;
          default: data_in = 16'($urandom);
        endcase
      end else if (k < 450) begin
        en = 1'b1; on_change = 1'b1; data_in = 16'h1234;
      end else begin
        en = (k == 450) ? 1'b1 : 1'($urandom_range(0, 1));
        on_change = 1'b1; data_in = 16'h1235;
      end
      if (k == 60) begin
        en = 1'b1; on_change = 1'b0;
      end
      tx_done = 1'($urandom_range(0, 1));  // ignored in IDLE
      send = en && (!on_change || !last_valid || data_in != last_word);
      if (send) begin
        plan_frame(i, data_in, k == 60, nxt);
        last_word  = data_in;
        last_valid = 1'b1;
      end else begin
        nxt = i + 1;
      end
      while (cyc < nxt) begin
        step();
        if (k == 60 && cyc == i + 6) begin
          rst_n = 1'b0;
          #1 check_all_zero("rst_async");
          for (int c = cyc + 1; c < MAXC; c++) begin
            exp_ts[c] = 1'b0; exp_fd[c] = 1'b0; exp_to[c] = 1'b0;
            exp_bz[c] = 1'b0; drv_done[c] = 1'b0;
          end
          mdout      = '0;
          last_valid = 1'b0;
          tx_done    = 1'b0;
          repeat (3) step();
          rst_n    = 1'b1;
          post_rst = 1'b1;
          nxt      = cyc;
          break;
        end
        if ($urandom_range(0, 3) == 0) data_in = 16'($urandom);
        en        = 1'($urandom_range(0, 1));
        on_change = 1'($urandom_range(0, 1));
      end
      i = nxt;
    end

    en = 1'b0;
    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
